// File: rtl/vedic_mul_rr_arbiter.sv
// Round-robin front end sharing one external combinational 8x8 Vedic multiplier
// among NUM_REQ requesters; operands and product are both registered.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no operation in flight, ready to accept a request
//   CALC  | operands on mul_a/mul_b, multiplier settling this cycle
//   DONE  | product held on res_y/res_id, res_valid high until consumed
module vedic_mul_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [8*NUM_REQ-1:0] req_a,
   input  logic [8*NUM_REQ-1:0] req_b,
   output logic [7:0]           mul_a,
   output logic [7:0]           mul_b,
   input  logic [15:0]          mul_y,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [15:0]          res_y,
   output logic [ID_W-1:0]      res_id,
   output logic                 busy
);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("vedic_mul_rr_arbiter: NUM_REQ must be 2..8");
   end
   if (ID_W < $clog2(NUM_REQ)) begin : g_bad_id_w
      $error("vedic_mul_rr_arbiter: ID_W too narrow for NUM_REQ");
   end

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] id_q;
   int              grant_idx;
   logic            grant_found;
   logic            accept;
   logic            handshake;

   // Search starts at rr_ptr and wraps modulo NUM_REQ, so non-power-of-2 counts work.
   always_comb begin
      grant_idx   = 0;
      grant_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_found && req_valid[idx]) begin
            grant_idx   = idx;
            grant_found = 1'b1;
         end
      end
   end

   assign accept    = !rst && ((state == IDLE) || (state == DONE && res_ready));
   assign handshake = accept && grant_found;

   always_comb begin
      req_ready = '0;
      if (handshake) req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         id_q      <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         res_y     <= '0;
         res_id    <= '0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  mul_a  <= req_a[8*grant_idx +: 8];
                  mul_b  <= req_b[8*grant_idx +: 8];
                  id_q   <= ID_W'(grant_idx);
                  rr_ptr <= (grant_idx == NUM_REQ-1) ? '0 : ID_W'(grant_idx + 1);
                  state  <= CALC;
                  busy   <= 1'b1;
               end
            end
            CALC: begin
               res_y     <= mul_y;
               res_id    <= id_q;
               state     <= DONE;
               res_valid <= 1'b1;
               busy      <= 1'b1;
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (handshake) begin
                     mul_a  <= req_a[8*grant_idx +: 8];
                     mul_b  <= req_b[8*grant_idx +: 8];
                     id_q   <= ID_W'(grant_idx);
                     rr_ptr <= (grant_idx == NUM_REQ-1) ? '0 : ID_W'(grant_idx + 1);
                     state  <= CALC;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               res_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vedic_mul_rr_arbiter.sv
// Bench for vedic_mul_rr_arbiter: behavioural model checked every cycle, directed
// scenarios with literal expectations, and a randomized 10k-operation stream.
module tb_vedic_mul_rr_arbiter;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid, req_ready;
   logic [31:0] req_a, req_b;
   logic [7:0]  mul_a, mul_b;
   logic [15:0] mul_y;
   logic        res_valid, res_ready;
   logic [15:0] res_y;
   logic [1:0]  res_id;
   logic        busy;

   logic [2:0]  r3_valid, r3_ready;
   logic [23:0] r3_a, r3_b;
   logic [7:0]  m3_a, m3_b;
   logic [15:0] m3_y;
   logic        r3_res_valid;
   logic [15:0] r3_res_y;
   logic [1:0]  r3_res_id;
   logic        r3_busy;

   always #5 clk = ~clk;

   // Stand-ins for the shared combinational Vedic multipliers.
   assign mul_y = 16'(mul_a) * 16'(mul_b);
   assign m3_y  = 16'(m3_a) * 16'(m3_b);

   vedic_mul_rr_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
      .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_id(res_id),
      .busy(busy));

   vedic_mul_rr_arbiter #(.NUM_REQ(3), .ID_W(2)) dut3 (
      .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready),
      .req_a(r3_a), .req_b(r3_b), .mul_a(m3_a), .mul_b(m3_b), .mul_y(m3_y),
      .res_valid(r3_res_valid), .res_ready(1'b1), .res_y(r3_res_y), .res_id(r3_res_id),
      .busy(r3_busy));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int find_grant(input int ptr, input logic [3:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // Model: an op is either in flight (one cycle) or a result is held until consumed.
   typedef struct { int id; logic [15:0] y; } sb_t;
   sb_t         sbq[$];
   int          m_rr = 0;
   bit          m_calc = 0, m_hold = 0;
   logic [15:0] m_y = '0, m_pend_y = '0;
   int          m_id = 0, m_pend_id = 0;
   logic [7:0]  m_a = '0, m_b = '0;

   always @(posedge clk or posedge rst) begin : model
      int g;
      bit acc;
      sb_t e;
      if (rst) begin
         m_rr = 0; m_calc = 0; m_hold = 0; m_y = '0; m_id = 0;
         m_a = '0; m_b = '0; m_pend_y = '0; m_pend_id = 0;
         sbq.delete();
      end else begin
         g   = find_grant(m_rr, req_valid);
         acc = (!m_calc && !m_hold) || (m_hold && res_ready);
         if (m_calc) begin
            m_y = m_pend_y; m_id = m_pend_id; m_hold = 1; m_calc = 0;
         end else if (acc) begin
            m_hold = 0;
            if (g >= 0) begin
               m_a       = req_a[8*g +: 8];
               m_b       = req_b[8*g +: 8];
               m_pend_y  = 16'(int'(m_a) * int'(m_b));
               m_pend_id = g;
               m_rr      = (g + 1) % N;
               m_calc    = 1;
               e.id = g; e.y = m_pend_y;
               sbq.push_back(e);
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      int g;
      logic [3:0] er;
      sb_t e;
      g  = find_grant(m_rr, req_valid);
      er = '0;
      if (!rst && g >= 0 && ((!m_calc && !m_hold) || (m_hold && res_ready))) er[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("res_valid", 32'(res_valid), 32'(m_hold));
      chk("busy",      32'(busy),      32'(m_calc || m_hold));
      chk("res_y",     32'(res_y),     32'(m_y));
      chk("res_id",    32'(res_id),    32'(m_id));
      chk("mul_a",     32'(mul_a),     32'(m_a));
      chk("mul_b",     32'(mul_b),     32'(m_b));
      if (!rst && res_valid && res_ready) begin
         if (sbq.size() == 0) chk("sb_unexpected_result", 32'd1, 32'd0);
         else begin
            e = sbq.pop_front();
            chk("sb_id", 32'(res_id), 32'(e.id));
            chk("sb_y",  32'(res_y),  32'(e.y));
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic wait_r3(output logic [2:0] got);
      got = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (r3_ready != 0) begin got = r3_ready; return; end
      end
   endtask

   function automatic logic [7:0] rnd_byte();
      int s;
      s = $urandom_range(7);
      if (s == 0) return 8'h00;
      if (s == 1) return 8'hFF;
      return 8'($urandom_range(255));
   endfunction

   logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [15:0] exp_p [4] = '{16'd15, 16'd63, 16'h0100, 16'h0100};
   logic [3:0]  gr [5];
   int          gc [5];
   logic [15:0] ry [4];

   initial begin
      logic [2:0] got3;
      logic [3:0] hs;
      int ng, nres, ops, cyc;

      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
      r3_valid = '0; r3_a = '0; r3_b = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // NUM_REQ=3 wrap: req1 moves rr_ptr to 2, then req2 beats req0, then req0.
      r3_valid = 3'b010; r3_a = {8'd4, 8'd3, 8'd2}; r3_b = {8'd5, 8'd6, 8'd7};
      wait_r3(got3); chk("t5_first_req1", 32'(got3), 32'b010);
      tick(); r3_valid = 3'b101;
      wait_r3(got3); chk("t5_req2_before_req0", 32'(got3), 32'b100);
      tick(); r3_valid = 3'b001;
      wait_r3(got3); chk("t5_wrap_to_req0", 32'(got3), 32'b001);
      tick(); r3_valid = '0;
      repeat (3) tick();

      // Single request 0xFF*0xFF, latency 2.
      req_a[7:0] = 8'hFF; req_b[7:0] = 8'hFF; req_valid = 4'b0001;
      @(negedge clk); chk("t2_ready", 32'(req_ready), 32'b0001);
      tick(); req_valid = '0;
      @(posedge clk); @(negedge clk);
      chk("t2_res_valid", 32'(res_valid), 32'd1);
      chk("t2_res_y", 32'(res_y), 32'hFE01);
      chk("t2_res_id", 32'(res_id), 32'd0);
      tick(); tick();

      // Round robin with all requesters continuously valid.
      do_reset();
      req_a = {8'h80, 8'h10, 8'd7, 8'd3}; req_b = {8'd2, 8'h10, 8'd9, 8'd5};
      req_valid = 4'hF; ng = 0; nres = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (req_ready != 0 && ng < 5) begin gr[ng] = req_ready; gc[ng] = c; ng++; end
         if (res_valid && nres < 4) begin ry[nres] = res_y; nres++; end
         tick();
      end
      req_valid = '0;
      chk("t3_grant_count", 32'(ng), 32'd5);
      chk("t3_result_count", 32'(nres), 32'd4);
      for (int i = 0; i < ng; i++) chk("t3_grant_order", 32'(gr[i]), 32'(exp_g[i]));
      for (int i = 1; i < ng; i++) chk("t3_grant_spacing", 32'(gc[i] - gc[i-1]), 32'd2);
      for (int i = 0; i < nres; i++) chk("t3_product", 32'(ry[i]), 32'(exp_p[i]));
      repeat (3) tick();

      // Backpressure: result held 5 cycles, then req2 accepted when consumed.
      do_reset();
      req_a = {8'd0, 8'd11, 8'd0, 8'd6}; req_b = {8'd0, 8'd13, 8'd0, 8'd7};
      res_ready = 1'b0; req_valid = 4'b0001;
      @(negedge clk); chk("t4_ready0", 32'(req_ready), 32'b0001);
      tick(); req_valid = '0;
      tick(); req_valid = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", 32'(res_valid), 32'd1);
         chk("t4_hold_y", 32'(res_y), 32'd42);
         chk("t4_hold_id", 32'(res_id), 32'd0);
         chk("t4_hold_ready", 32'(req_ready), 32'd0);
         tick();
      end
      res_ready = 1'b1;
      @(negedge clk); chk("t4_same_cycle_accept", 32'(req_ready), 32'b0100);
      tick(); req_valid = '0;
      @(posedge clk); @(negedge clk);
      chk("t4_res_y", 32'(res_y), 32'd143);
      chk("t4_res_id", 32'(res_id), 32'd2);
      tick(); tick();

      // Reset during CALC drops the operation.
      do_reset();
      req_a = {8'd0, 8'd0, 8'd9, 8'd0}; req_b = {8'd0, 8'd0, 8'd9, 8'd0};
      req_valid = 4'b0010;
      @(negedge clk); chk("t1_ready", 32'(req_ready), 32'b0010);
      tick();
      @(negedge clk); #2 rst = 1'b1; #1;
      chk("t1_rst_outputs", {busy, res_valid, req_ready, res_id, res_y, mul_a | mul_b},
          32'd0);
      req_valid = '0;
      @(negedge clk); #2 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("t1_no_stale_result", 32'(res_valid), 32'd0);
      end
      tick();

      // Randomized stream, checked by the model and scoreboard.
      do_reset();
      ops = 0; cyc = 0;
      while (ops < 10000 && cyc < 60000) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         if (hs != 0) ops++;
         tick(); cyc++;
         for (int i = 0; i < N; i++) begin
            if (hs[i] || !req_valid[i]) begin
               if ($urandom_range(99) < 60) begin
                  req_valid[i]    = 1'b1;
                  req_a[8*i +: 8] = rnd_byte();
                  req_b[8*i +: 8] = rnd_byte();
               end else req_valid[i] = 1'b0;
            end
         end
         res_ready = ($urandom_range(99) < 75);
      end
      chk("t6_ops_completed", 32'(ops >= 10000), 32'd1);
      req_valid = '0; res_ready = 1'b1;
      repeat (4) tick();
      chk("t6_scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
